ps2_host_tx: RTL

Host-to-device PS/2 frame transmitter: sends one command byte (LED set `0xED`, reset `0xFF`, etc.) from the CPLD to the keyboard over the shared open-drain clock/data pair. It is clocked by the keyboard-generated PS/2 clock and sits beside the PS/2 receive path. The host-side controller handles the 100 µs clock inhibit in its own clock domain. Request and completion cross domains with toggle handshakes, so no pulse has to survive the domain crossing.

---
 rtl/ps2_host_tx_if.sv | 21 ++
 rtl/ps2_host_tx.sv | 88 ++++++++
 2 files changed

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: request/completion handshake and open-drain line controls of the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic       tx_req_tgl;
  logic [7:0] tx_byte;
  logic       inhibit;
  logic       ps2_data_in;
  logic       ps2_clk_low;
  logic       ps2_data_low;
  logic       tx_done_tgl;
  logic       ack_err;
  logic       busy;
  logic [3:0] bit_cnt;
  modport master (
    output tx_req_tgl, tx_byte, inhibit, ps2_data_in,
    input  ps2_clk_low, ps2_data_low, tx_done_tgl, ack_err, busy, bit_cnt
  );
  modport slave (
    input  tx_req_tgl, tx_byte, inhibit, ps2_data_in,
    output ps2_clk_low, ps2_data_low, tx_done_tgl, ack_err, busy, bit_cnt
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 frame transmitter clocked by the device's falling clock edges.
// Define PS2_TX_ACK_CHECK_EN to sample the device ACK on edge 11; otherwise the frame ends on edge 10.
module ps2_host_tx (
  input logic          ps2_nclk,
  input logic          nReset,
  ps2_host_tx_if.slave b
);
  typedef enum logic [2:0] {IDLE, SHIFT, PARITY, STOP, ACK} state_t;
  state_t     r_state;
  logic [7:0] r_sr;
  logic       r_par;
  logic       r_drv_low;
  logic       r_done;
  logic [3:0] r_cnt;
  logic       w_pending;
  logic [3:0] w_cnt_nxt;
  logic       w_unused;
`ifdef PS2_TX_ACK_CHECK_EN
  logic       r_ack_err;
  assign b.ack_err = r_ack_err;
  assign w_unused  = r_sr[0];
`else
  assign b.ack_err = 1'b0;
  assign w_unused  = ^{r_sr[0], b.ps2_data_in};
`endif
  assign w_pending = b.tx_req_tgl ^ r_done;
  assign w_cnt_nxt = (r_cnt == 4'd11) ? 4'd11 : r_cnt + 4'd1;
  // Start bit is asserted while still in IDLE; reset releases the line at once.
  assign b.ps2_data_low = nReset & (((r_state == IDLE) & w_pending) | r_drv_low);
  assign b.ps2_clk_low  = b.inhibit;
  assign b.busy         = w_pending | (r_state != IDLE);
  assign b.tx_done_tgl  = r_done;
  assign b.bit_cnt      = r_cnt;
  always_ff @(negedge ps2_nclk or negedge nReset)
    if (!nReset) begin
      r_state   <= IDLE;
      r_sr      <= 8'd0;
      r_par     <= 1'b0;
      r_drv_low <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= 4'd0;
`ifdef PS2_TX_ACK_CHECK_EN
      r_ack_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE:
          if (w_pending) begin
            r_sr      <= b.tx_byte;
            r_drv_low <= ~b.tx_byte[0];
            r_par     <= ~b.tx_byte[0];
            r_cnt     <= 4'd1;
            r_state   <= SHIFT;
          end
        SHIFT: begin
          r_cnt <= w_cnt_nxt;
          if (r_cnt == 4'd8) begin
            r_drv_low <= ~r_par;
            r_state   <= PARITY;
          end else begin
            r_sr      <= r_sr >> 1;
            r_drv_low <= ~r_sr[1];
            r_par     <= r_par ^ r_sr[1];
          end
        end
        PARITY: begin
          r_drv_low <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
          r_cnt   <= w_cnt_nxt;
          r_state <= STOP;
`else
          r_cnt   <= 4'd0;
          r_done  <= ~r_done;
          r_state <= IDLE;
`endif
        end
`ifdef PS2_TX_ACK_CHECK_EN
        STOP: begin
          r_ack_err <= b.ps2_data_in;
          r_done    <= ~r_done;
          r_cnt     <= 4'd0;
          r_state   <= IDLE;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
endmodule
